// File: rtl/mic_pkg.sv
// Shared constants for the microphone jump detector: divider, window and
// holdoff lengths for normal and test mode, plus the FSM state encoding.
package mic_pkg;

  localparam logic [5:0] HALF_NORM = 6'd20;
  localparam logic [5:0] HALF_TEST = 6'd2;

  localparam logic [8:0] WIN_NORM  = 9'd256;
  localparam logic [8:0] WIN_TEST  = 9'd16;

  localparam logic [4:0] HOLD_NORM = 5'd16;
  localparam logic [4:0] HOLD_TEST = 5'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRE   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_REARM  = 2'd3;

  // Distance of the ones count from the window midpoint; never exceeds 128.
  function automatic logic [7:0] abs_dev(input logic [8:0] ones, input logic [8:0] mid);
    return 8'((ones >= mid) ? (ones - mid) : (mid - ones));
  endfunction

endpackage

// File: rtl/mic_jump_detect_if.sv
// PDM microphone pins. The detector is the master (drives the mic clock and
// channel select); the microphone model is the slave (drives the data line).
interface mic_jump_detect_if;
  logic M_CLK;
  logic M_LRSEL;
  logic M_DATA;

  modport master (output M_CLK, output M_LRSEL, input M_DATA);
  modport slave  (input M_CLK, input M_LRSEL, output M_DATA);
endinterface

// File: rtl/mic_clk_gen.sv
// Microphone clock divider, data synchronizer and sample strobe.
// M_CLK is registered from the next divider value so it is glitch-free and
// aligned with div_cnt; the strobe marks the last high cycle of M_CLK.
module mic_clk_gen
  import mic_pkg::*;
(
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic clr,
  input  logic istesting,
  input  logic m_data,
  output logic m_clk,
  output logic sample_stb,
  output logic sample_bit
);

  logic [5:0] div_cnt;
  logic [5:0] div_nxt;
  logic [5:0] half;
  logic [5:0] div_top;
  logic       sync_1;
  logic       sync_2;

  // Next divider value: wrap at 2*HALF-1, forced to 0 while cleared.
  always_comb begin
    half    = istesting ? HALF_TEST : HALF_NORM;
    div_top = (half << 1) - 6'd1;
    if (clr) begin
      div_nxt = '0;
    end else if (div_cnt == div_top) begin
      div_nxt = '0;
    end else begin
      div_nxt = div_cnt + 6'd1;
    end
  end

  // Divider counter and registered microphone clock.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      div_cnt <= '0;
      m_clk   <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      m_clk   <= (div_nxt >= half);
    end
  end

  // Two-flop synchronizer for the asynchronous PDM data line.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= m_data;
      sync_2 <= sync_1;
    end
  end

  assign sample_stb = !clr && (div_cnt == div_top);
  assign sample_bit = sync_2;

endmodule

// File: rtl/mic_jump_detect.sv
// Loudness-triggered jump detector: counts PDM ones per window, reports the
// deviation from the midpoint as level, and fires one jump per loud event.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | armed; a window with level >= threshold fires
// FIRE     | one-cycle jump pulse
// HOLD     | ignore levels for HOLD_WIN windows after a jump
// REARM    | wait for a quiet window (level < threshold) before re-arming
module mic_jump_detect
  import mic_pkg::*;
(
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  mic_jump_detect_if.master  mic,
  input  logic               mic_en,
  input  logic               istesting,
  input  logic [7:0]         threshold,
  output logic [7:0]         level,
  output logic               level_valid,
  output logic               jump
);

  logic       ist_q;
  logic       clr;
  logic       sample_stb;
  logic       sample_bit;
  logic [7:0] samp_cnt;
  logic [8:0] ones;
  logic [8:0] ones_tot;
  logic [8:0] win_len;
  logic [8:0] win_m1;
  logic [8:0] win_mid;
  logic [4:0] hold_m1;
  logic [4:0] hold_cnt;
  logic [1:0] state;

  assign mic.M_LRSEL = 1'b0;

  // Track istesting so a mode change restarts everything; not reset, so
  // leaving reset never looks like a mode change.
  always_ff @(posedge CLK100MHZ) begin
    ist_q <= istesting;
  end

  assign clr = !mic_en || (istesting != ist_q);

  mic_clk_gen u_clk_gen (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .clr        (clr),
    .istesting  (istesting),
    .m_data     (mic.M_DATA),
    .m_clk      (mic.M_CLK),
    .sample_stb (sample_stb),
    .sample_bit (sample_bit)
  );

  // Mode-dependent window and holdoff limits.
  always_comb begin
    win_len  = istesting ? WIN_TEST : WIN_NORM;
    win_m1   = win_len - 9'd1;
    win_mid  = win_len >> 1;
    hold_m1  = (istesting ? HOLD_TEST : HOLD_NORM) - 5'd1;
    ones_tot = ones + {8'd0, sample_bit};
  end

  // Window accumulator; the closing sample publishes level and restarts.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      samp_cnt    <= '0;
      ones        <= '0;
      level       <= '0;
      level_valid <= 1'b0;
    end else if (clr) begin
      samp_cnt    <= '0;
      ones        <= '0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (sample_stb) begin
        if ({1'b0, samp_cnt} == win_m1) begin
          level       <= abs_dev(ones_tot, win_mid);
          level_valid <= 1'b1;
          samp_cnt    <= '0;
          ones        <= '0;
        end else begin
          samp_cnt <= samp_cnt + 8'd1;
          ones     <= ones_tot;
        end
      end
    end
  end

  // Jump FSM: all states except FIRE advance only on a level update.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else if (clr) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (level_valid && (level >= threshold)) begin
            state <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          state    <= ST_HOLD;
          hold_cnt <= '0;
        end
        ST_HOLD: begin
          if (level_valid) begin
            if (hold_cnt == hold_m1) begin
              state <= ST_REARM;
            end else begin
              hold_cnt <= hold_cnt + 5'd1;
            end
          end
        end
        ST_REARM: begin
          if (level_valid && (level < threshold)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign jump = (state == ST_FIRE);

endmodule

// File: doc/mic_jump_detect.md
MIC_JUMP_DETECT -- requirements
Module: mic_jump_detect

Interface
REQ-001 Parameters (name, default, meaning): none; all constants come from the shared package (REQ-030).
REQ-002 CLK100MHZ  in  1  system clock, 100 MHz; the only clock.
REQ-003 CPU_RESETN  in  1  reset; synchronous, active-low.
REQ-004 M_DATA  in  1  PDM bit stream from the onboard microphone; asynchronous to the block.
REQ-005 mic_en  in  1  1 = run the microphone and the detector; 0 = idle.
REQ-006 istesting  in  1  1 = short divider, window and holdoff, for simulation; static during operation.
REQ-007 threshold  in  8  loudness threshold, unsigned.
REQ-008 M_CLK  out  1  microphone clock.
REQ-009 M_LRSEL  out  1  microphone channel select; tied to 0.
REQ-010 level  out  8  loudness of the last completed window, unsigned.
REQ-011 level_valid  out  1  one-cycle strobe when level updates.
REQ-012 jump  out  1  one-cycle pulse requesting a player jump.

Function
REQ-013 Divider: counter div_cnt runs 0..2*HALF-1 and wraps; HALF = 20 (normal) or 2 (istesting).
REQ-014 M_CLK = 1 while div_cnt >= HALF, giving 2.5 MHz at 50% duty in normal mode.
REQ-015 M_DATA passes through a 2-flop synchronizer before it is used.
REQ-016 Sample strobe: one cycle when div_cnt == 2*HALF-1; the synchronized M_DATA is taken on that cycle.
REQ-017 Window: WIN = 256 (normal) or 16 (istesting) samples; sample counter runs 0..WIN-1.
REQ-018 Window accumulator: 9-bit ones count of sampled 1s; cleared at window start; never overflows, since the maximum is 256.
REQ-019 The cycle after the last sample of a window:
- level <= |ones - WIN/2| (0..128, zero-extended to 8 bits);
- level_valid = 1;
- ones and the sample counter restart.
REQ-020 FSM states: IDLE, FIRE, HOLD, REARM. Each evaluates only on level_valid, except FIRE.
REQ-021 IDLE: if level >= threshold, go to FIRE.
REQ-022 FIRE: lasts exactly one cycle with jump = 1, then goes to HOLD with the hold counter cleared. jump is therefore asserted the cycle after level_valid.
REQ-023 HOLD: counts level_valid strobes. After HOLD_WIN strobes (16 normal, 2 istesting), go to REARM; level is ignored in HOLD.
REQ-024 REARM: the first window with level < threshold returns the FSM to IDLE; loud windows keep it in REARM. A sustained sound produces exactly one jump.
REQ-025 threshold = 0: every window qualifies as loud. The bench must see one jump, then the FSM stays in REARM indefinitely.
REQ-026 mic_en = 0, synchronously on the next edge:
- M_CLK held 0;
- div_cnt, sample counter and ones cleared;
- FSM to IDLE; jump and level_valid held 0;
- level retains its value.
REQ-027 mic_en rising: the first window starts at div_cnt = 0.
REQ-028 A change of istesting clears div_cnt, the sample counter and ones on the next cycle, and the FSM goes to IDLE.

Reset
REQ-029 While CPU_RESETN = 0 at a clock edge:
- M_CLK, level, level_valid and jump = 0;
- all counters 0;
- FSM = IDLE;
- synchronizer flops = 0.
M_LRSEL is always 0. Reset mid-window discards the partial window.

Structure
REQ-030 Shared package mic_pkg holds:
- HALF_NORM = 20, HALF_TEST = 2;
- WIN_NORM = 256, WIN_TEST = 16;
- HOLD_NORM = 16, HOLD_TEST = 2;
- the FSM state encoding.
REQ-031 One sub-module, mic_clk_gen: the divider, M_CLK, the synchronizer and the sample strobe. The accumulator and FSM live in the top module.

Verification
REQ-032 Reset, then mic_en = 1, istesting = 0 -> M_CLK period 40 cycles, high 20 cycles; strobe on the last high cycle.
REQ-033 istesting = 0, threshold = 48, M_DATA = 1 constant -> level = 128 with level_valid after 256 samples; jump pulse exactly 1 cycle long, the cycle after level_valid; no second jump while M_DATA stays 1.
REQ-034 istesting = 1, M_DATA alternating per sample -> ones = 8, level = 0 each window, jump never asserted.
REQ-035 istesting = 1, threshold = 4, loud window (level 8), then 2 loud windows, 1 quiet window, 1 loud window -> jump on the first window and again on the last window only.
REQ-036 CPU_RESETN pulsed low for 1 cycle mid-window, istesting = 1 -> all outputs 0 next cycle; the next level_valid comes a full 16 samples after reset release.
REQ-037 mic_en dropped during HOLD, then raised -> M_CLK stays low while mic_en = 0; FSM is in IDLE and a loud window fires jump immediately.
